// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the main-memory port arbiter: owner ids, FSM states, field widths.
package mem_port_arbiter_pkg;

  localparam int MEM_OWNER_WIDTH = 1;
  localparam logic [MEM_OWNER_WIDTH-1:0] MEM_OWNER_IF = 1'b0;
  localparam logic [MEM_OWNER_WIDTH-1:0] MEM_OWNER_LS = 1'b1;

  localparam int MEM_BE_WIDTH = 4;
  localparam int CNT_WIDTH    = 4;
  localparam int STARVE_WIDTH = 4;
  localparam logic [STARVE_WIDTH-1:0] STARVE_MAX = 4'hF;

  typedef enum logic {
    ARB_STATE_IDLE = 1'b0,
    ARB_STATE_BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/mem_arb_prio.sv
// Winner select for the memory port: LS by default, IF once it has lost STARVE_LIMIT times in a row.
module mem_arb_prio
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic if_req,
  input  logic ls_req,
  input  logic window,
  output logic grant_if,
  output logic grant_ls
);

  localparam logic [STARVE_WIDTH-1:0] LIMIT_C = STARVE_WIDTH'(STARVE_LIMIT);

  logic [STARVE_WIDTH-1:0] starve_r;
  logic                    if_first_s;

  // Winner select; grants only exist while a grant window is open.
  always_comb begin
    grant_if   = 1'b0;
    grant_ls   = 1'b0;
    if_first_s = (starve_r >= LIMIT_C);
    if (window) begin
      if (if_req && (!ls_req || if_first_s)) begin
        grant_if = 1'b1;
      end else if (ls_req) begin
        grant_ls = 1'b1;
      end else begin
        grant_if = 1'b0;
      end
    end else begin
      grant_ls = 1'b0;
    end
  end

  // Count consecutive arbitrations IF lost to LS; cycles without a window leave it untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_r <= '0;
    end else if (grant_if) begin
      starve_r <= '0;
    end else if (grant_ls && if_req && (starve_r != STARVE_MAX)) begin
      starve_r <= starve_r + 4'd1;
    end else begin
      starve_r <= starve_r;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one main-memory port between instruction fetch and load/store, one transaction
// in flight at a time, routing each response back to the requester that issued it.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    if_req,
  input  logic [ADDR_WIDTH-1:0]   if_addr,
  output logic                    if_gnt,
  output logic                    if_stall,
  output logic                    if_rvalid,
  output logic [DATA_WIDTH-1:0]   if_rdata,
  output logic                    if_err,
  input  logic                    ls_req,
  input  logic                    ls_we,
  input  logic [MEM_BE_WIDTH-1:0] ls_be,
  input  logic [ADDR_WIDTH-1:0]   ls_addr,
  input  logic [DATA_WIDTH-1:0]   ls_wdata,
  output logic                    ls_gnt,
  output logic                    ls_rvalid,
  output logic [DATA_WIDTH-1:0]   ls_rdata,
  output logic                    ls_err,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [MEM_BE_WIDTH-1:0] mem_be,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  input  logic                    mem_error
);

  localparam logic [CNT_WIDTH-1:0] LAT_C = CNT_WIDTH'(MEM_LATENCY);

  arb_state_e                 state_r;
  logic [MEM_OWNER_WIDTH-1:0] owner_r;
  logic [CNT_WIDTH-1:0]       cnt_r;
  logic                       store_r;
  logic                       done_s;
  logic                       window_s;
  logic                       grant_if_s;
  logic                       grant_ls_s;
  logic                       issue_s;

  assign done_s   = (state_r == ARB_STATE_BUSY) && (cnt_r == 4'd1);
  assign window_s = (state_r == ARB_STATE_IDLE) || done_s;
  assign issue_s  = grant_if_s || grant_ls_s;

  mem_arb_prio #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_prio (
    .clk      (clk),
    .reset    (reset),
    .if_req   (if_req),
    .ls_req   (ls_req),
    .window   (window_s),
    .grant_if (grant_if_s),
    .grant_ls (grant_ls_s)
  );

  // Request forwarding and response routing; everything is forced quiet while reset is high.
  always_comb begin
    if_gnt    = 1'b0;
    if_stall  = 1'b0;
    if_rvalid = 1'b0;
    if_rdata  = '0;
    if_err    = 1'b0;
    ls_gnt    = 1'b0;
    ls_rvalid = 1'b0;
    ls_rdata  = '0;
    ls_err    = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (!reset) begin
      if_gnt   = grant_if_s;
      ls_gnt   = grant_ls_s;
      if_stall = if_req && !grant_if_s;
      if (grant_if_s) begin
        mem_req  = 1'b1;
        mem_be   = 4'hF;
        mem_addr = if_addr;
      end else if (grant_ls_s) begin
        mem_req   = 1'b1;
        mem_we    = ls_we;
        mem_be    = ls_be;
        mem_addr  = ls_addr;
        mem_wdata = ls_wdata;
      end else begin
        mem_req = 1'b0;
      end
      // The response is a pass-through of the memory bus in the completion cycle.
      if (done_s && (owner_r == MEM_OWNER_IF)) begin
        if_rvalid = 1'b1;
        if_rdata  = mem_rdata;
        if_err    = mem_error;
      end else if (done_s) begin
        ls_rvalid = 1'b1;
        ls_rdata  = store_r ? '0 : mem_rdata;
        ls_err    = mem_error;
      end else begin
        ls_rvalid = 1'b0;
      end
    end else begin
      if_gnt = 1'b0;
    end
  end

  // Transaction tracker: IDLE until a grant, then BUSY counting down to the response.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ARB_STATE_IDLE;
      owner_r <= MEM_OWNER_IF;
      cnt_r   <= '0;
      store_r <= 1'b0;
    end else begin
      case (state_r)
        ARB_STATE_IDLE, ARB_STATE_BUSY: begin
          if (issue_s) begin
            state_r <= ARB_STATE_BUSY;
            owner_r <= grant_ls_s ? MEM_OWNER_LS : MEM_OWNER_IF;
            cnt_r   <= LAT_C;
            store_r <= grant_ls_s && ls_we;
          end else if ((state_r == ARB_STATE_BUSY) && (cnt_r > 4'd1)) begin
            cnt_r <= cnt_r - 4'd1;
          end else begin
            state_r <= ARB_STATE_IDLE;
            cnt_r   <= '0;
          end
        end
        default: begin
          state_r <= ARB_STATE_IDLE;
          cnt_r   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: two arbiters (latency 1 and 3) driven by directed vectors, with a
// behavioural memory and per-instance scoreboards checked by negedge monitors.
module tb_mem_port_arbiter;

  typedef struct {
    logic        is_ls;
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  exp_t qa[$];
  exp_t qb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance A: latency 1
  logic        a_reset, a_if_req, a_if_gnt, a_if_stall, a_if_rvalid, a_if_err;
  logic [31:0] a_if_addr, a_if_rdata;
  logic        a_ls_req, a_ls_we, a_ls_gnt, a_ls_rvalid, a_ls_err;
  logic [3:0]  a_ls_be, a_mem_be;
  logic [31:0] a_ls_addr, a_ls_wdata, a_ls_rdata;
  logic        a_mem_req, a_mem_we, a_mem_error;
  logic [31:0] a_mem_addr, a_mem_wdata, a_mem_rdata;
  // Instance B: latency 3
  logic        b_reset, b_if_req, b_if_gnt, b_if_stall, b_if_rvalid, b_if_err;
  logic [31:0] b_if_addr, b_if_rdata;
  logic        b_ls_req, b_ls_we, b_ls_gnt, b_ls_rvalid, b_ls_err;
  logic [3:0]  b_ls_be, b_mem_be;
  logic [31:0] b_ls_addr, b_ls_wdata, b_ls_rdata;
  logic        b_mem_req, b_mem_we, b_mem_error;
  logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;

  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(1), .STARVE_LIMIT(4)) dut_a (
    .clk(clk), .reset(a_reset),
    .if_req(a_if_req), .if_addr(a_if_addr), .if_gnt(a_if_gnt), .if_stall(a_if_stall),
    .if_rvalid(a_if_rvalid), .if_rdata(a_if_rdata), .if_err(a_if_err),
    .ls_req(a_ls_req), .ls_we(a_ls_we), .ls_be(a_ls_be), .ls_addr(a_ls_addr),
    .ls_wdata(a_ls_wdata), .ls_gnt(a_ls_gnt), .ls_rvalid(a_ls_rvalid),
    .ls_rdata(a_ls_rdata), .ls_err(a_ls_err),
    .mem_req(a_mem_req), .mem_we(a_mem_we), .mem_be(a_mem_be), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata), .mem_error(a_mem_error)
  );

  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(3), .STARVE_LIMIT(4)) dut_b (
    .clk(clk), .reset(b_reset),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt), .if_stall(b_if_stall),
    .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata), .if_err(b_if_err),
    .ls_req(b_ls_req), .ls_we(b_ls_we), .ls_be(b_ls_be), .ls_addr(b_ls_addr),
    .ls_wdata(b_ls_wdata), .ls_gnt(b_ls_gnt), .ls_rvalid(b_ls_rvalid),
    .ls_rdata(b_ls_rdata), .ls_err(b_ls_err),
    .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_be(b_mem_be), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .mem_error(b_mem_error)
  );

  // Memory content: data = addr ^ constant, error on any address with bit 31 set.
  function automatic logic [31:0] mem_val(input logic [31:0] addr);
    return addr ^ 32'h1357_9BDF;
  endfunction

  logic [32:0] a_dl;
  logic [32:0] b_dl0, b_dl1, b_dl2;
  always @(posedge clk) begin
    a_dl  <= {a_mem_req, a_mem_addr};
    b_dl0 <= {b_mem_req, b_mem_addr};
    b_dl1 <= b_dl0;
    b_dl2 <= b_dl1;
  end
  assign a_mem_rdata = a_dl[32] ? mem_val(a_dl[31:0]) : 32'h0BAD_F00D;
  assign a_mem_error = a_dl[32] & a_dl[31];
  assign b_mem_rdata = b_dl2[32] ? mem_val(b_dl2[31:0]) : 32'h0BAD_F00D;
  assign b_mem_error = b_dl2[32] & b_dl2[31];

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic void push_a(input logic is_ls, input logic [31:0] addr, input logic we);
    exp_t e;
    e.is_ls = is_ls; e.data = we ? 32'h0 : mem_val(addr); e.err = addr[31]; e.cyc = cyc + 1;
    qa.push_back(e);
  endfunction

  function automatic void push_b(input logic is_ls, input logic [31:0] addr, input logic we);
    exp_t e;
    e.is_ls = is_ls; e.data = we ? 32'h0 : mem_val(addr); e.err = addr[31]; e.cyc = cyc + 3;
    qb.push_back(e);
  endfunction

  task automatic score(input string tag, input exp_t e, input logic ifv, input logic lsv,
                       input logic [31:0] ifd, input logic [31:0] lsd,
                       input logic ife, input logic lse);
    check({tag, "_owner"}, 160'({ifv, lsv}), 160'(e.is_ls ? 2'b01 : 2'b10));
    check({tag, "_rdata"}, 160'(e.is_ls ? lsd : ifd), 160'(e.data));
    check({tag, "_err"}, 160'({ife, lse}), 160'(e.is_ls ? {1'b0, e.err} : {e.err, 1'b0}));
    check({tag, "_latency"}, 160'(cyc), 160'(e.cyc));
  endtask

  // Scoreboard monitors: every response pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (a_if_rvalid || a_ls_rvalid) begin
      if (qa.size() == 0) check("a_unexpected_rvalid", 160'({a_if_rvalid, a_ls_rvalid}), 160'd0);
      else score("a_resp", qa.pop_front(), a_if_rvalid, a_ls_rvalid, a_if_rdata, a_ls_rdata,
                 a_if_err, a_ls_err);
    end
  end

  always @(negedge clk) begin
    if (b_if_rvalid || b_ls_rvalid) begin
      if (qb.size() == 0) check("b_unexpected_rvalid", 160'({b_if_rvalid, b_ls_rvalid}), 160'd0);
      else score("b_resp", qb.pop_front(), b_if_rvalid, b_ls_rvalid, b_if_rdata, b_ls_rdata,
                 b_if_err, b_ls_err);
    end
  end

  function automatic logic [159:0] a_outs();
    return 160'({a_if_gnt, a_if_stall, a_if_rvalid, a_if_rdata, a_if_err, a_ls_gnt, a_ls_rvalid,
                 a_ls_rdata, a_ls_err, a_mem_req, a_mem_we, a_mem_be, a_mem_addr, a_mem_wdata});
  endfunction

  function automatic logic [159:0] b_outs();
    return 160'({b_if_gnt, b_if_stall, b_if_rvalid, b_if_rdata, b_if_err, b_ls_gnt, b_ls_rvalid,
                 b_ls_rdata, b_ls_err, b_mem_req, b_mem_we, b_mem_be, b_mem_addr, b_mem_wdata});
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic got;
    // Reset with requests pending on both sides: all outputs must stay quiet.
    a_reset = 1'b1; b_reset = 1'b1;
    a_if_req = 1'b1; a_if_addr = 32'h0; a_ls_req = 1'b1; a_ls_we = 1'b1; a_ls_be = 4'hF;
    a_ls_addr = 32'h55; a_ls_wdata = 32'hCAFE_0001;
    b_if_req = 1'b1; b_if_addr = 32'h4; b_ls_req = 1'b1; b_ls_we = 1'b0; b_ls_be = 4'hF;
    b_ls_addr = 32'h66; b_ls_wdata = 32'h0;
    repeat (2) begin
      @(negedge clk);
      check("a_reset_outputs", a_outs(), 160'd0);
      check("b_reset_outputs", b_outs(), 160'd0);
    end
    step();
    a_reset = 1'b0; b_reset = 1'b0;
    a_ls_req = 1'b0; a_ls_we = 1'b0; a_ls_wdata = 32'h0; b_if_req = 1'b0; b_ls_req = 1'b0;

    // 1: eight sequential fetches, one per cycle.
    for (int i = 0; i < 8; i++) begin
      a_if_addr = 32'(i * 4);
      @(negedge clk);
      check("t1_if_gnt", 160'({a_if_gnt, a_if_stall, a_mem_req}), 160'(3'b101));
      check("t1_mem_bus", 160'({a_mem_we, a_mem_be, a_mem_addr}), 160'({1'b0, 4'hF, 32'(i * 4)}));
      push_a(1'b0, a_if_addr, 1'b0);
      step();
    end
    a_if_req = 1'b0;

    // 2: simultaneous fetch and load; LS first, IF stalls exactly one cycle.
    a_if_req = 1'b1; a_if_addr = 32'h40; a_ls_req = 1'b1; a_ls_addr = 32'h100;
    @(negedge clk);
    check("t2_first_grant", 160'({a_ls_gnt, a_if_gnt, a_if_stall}), 160'(3'b101));
    push_a(1'b1, a_ls_addr, 1'b0);
    step();
    a_ls_req = 1'b0;
    @(negedge clk);
    check("t2_second_grant", 160'({a_ls_gnt, a_if_gnt, a_if_stall}), 160'(3'b010));
    push_a(1'b0, a_if_addr, 1'b0);
    step();
    a_if_req = 1'b0;

    // 3: LS hogs the port; IF gets every fifth grant.
    a_if_req = 1'b1; a_if_addr = 32'h80; a_ls_req = 1'b1; a_ls_addr = 32'h300;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t3_grants", 160'({a_if_gnt, a_ls_gnt}), 160'((i % 5 == 4) ? 2'b10 : 2'b01));
      if (i % 5 == 4) push_a(1'b0, a_if_addr, 1'b0);
      else push_a(1'b1, a_ls_addr, 1'b0);
      got = a_if_gnt;
      step();
      if (got) a_if_addr = a_if_addr + 32'd4;
      else a_ls_addr = a_ls_addr + 32'd4;
    end
    a_if_req = 1'b0; a_ls_req = 1'b0;

    // 5: error responses on a fetch and on a load.
    a_if_req = 1'b1; a_if_addr = 32'h8000_0040;
    @(negedge clk);
    check("t5_if_gnt", 160'(a_if_gnt), 160'(1'b1));
    push_a(1'b0, a_if_addr, 1'b0);
    step();
    a_if_req = 1'b0; a_ls_req = 1'b1; a_ls_addr = 32'h8000_0100;
    @(negedge clk);
    check("t5_ls_gnt", 160'(a_ls_gnt), 160'(1'b1));
    push_a(1'b1, a_ls_addr, 1'b0);
    step();
    a_ls_req = 1'b0;

    // 4: latency-3 store, then a load competing with a stalled fetch.
    b_ls_req = 1'b1; b_ls_we = 1'b1; b_ls_be = 4'b0011; b_ls_addr = 32'h200;
    b_ls_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check("t4_store_bus", 160'({b_ls_gnt, b_mem_req, b_mem_we, b_mem_be, b_mem_addr, b_mem_wdata}),
          160'({1'b1, 1'b1, 1'b1, 4'b0011, 32'h200, 32'hDEAD_BEEF}));
    push_b(1'b1, b_ls_addr, 1'b1);
    step();
    b_ls_we = 1'b0; b_ls_be = 4'hF; b_ls_addr = 32'h204; b_ls_wdata = 32'h0;
    b_if_req = 1'b1; b_if_addr = 32'h60;
    repeat (2) begin
      @(negedge clk);
      check("t4_no_grant_busy", 160'({b_if_gnt, b_ls_gnt, b_mem_req, b_mem_addr, b_if_stall}),
            160'({3'b000, 32'h0, 1'b1}));
      step();
    end
    @(negedge clk);
    check("t4_back_to_back", 160'({b_ls_gnt, b_if_gnt}), 160'(2'b10));
    push_b(1'b1, b_ls_addr, 1'b0);
    step();
    b_ls_req = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      if (b_if_gnt) begin
        got = 1'b1;
        push_b(1'b0, b_if_addr, 1'b0);
      end
      step();
    end
    check("t4_if_gnt_after_load", 160'(got), 160'(1'b1));
    b_if_req = 1'b0;
    repeat (5) step();

    // 6: reset while a latency-3 fetch is in flight; its response must vanish.
    b_if_req = 1'b1; b_if_addr = 32'h10;
    @(negedge clk);
    check("t6_if_gnt", 160'(b_if_gnt), 160'(1'b1));
    step();
    b_if_req = 1'b0;
    step();
    b_reset = 1'b1; b_if_req = 1'b1; b_if_addr = 32'h20; b_ls_req = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("t6_reset_outputs", b_outs(), 160'd0);
      step();
    end
    b_reset = 1'b0; b_ls_req = 1'b0;
    @(negedge clk);
    check("t6_resume_gnt", 160'({b_if_gnt, b_ls_gnt}), 160'(2'b10));
    push_b(1'b0, b_if_addr, 1'b0);
    step();
    b_if_req = 1'b0;

    // Drain: every expected response must have been seen.
    for (int k = 0; k < 20 && (qa.size() != 0 || qb.size() != 0); k++) step();
    check("a_pending_responses", 160'(qa.size()), 160'd0);
    check("b_pending_responses", 160'(qb.size()), 160'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
